// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the fetch (read-only) and data ports,
// data has priority except when fetch has been passed over STARVE_MAX times in a row.
module mem_arbiter #(
   parameter int AW         = 12,
   parameter int DW         = 16,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int LW = 3;
   typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;
   state_t        state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [LW-1:0] lat_q, lat_d;
   logic          owner_q, owner_d;
   logic          kill_q, kill_d;
   logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
   logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          busy_q, busy_d;
   logic          arb, sel_if, sel_dp, rd_done;
   always_comb begin
      arb         = state_q == IDLE || state_q == RESP;
      sel_if      = arb && if_req && (!d_req || starve_q == SW'(STARVE_MAX));
      sel_dp      = arb && d_req && !sel_if;
      rd_done     = state_q == WAIT && lat_q == '0;
      mem_en_d    = sel_if || sel_dp;
      mem_we_d    = sel_dp && d_we;
      mem_addr_d  = sel_dp ? d_addr : sel_if ? if_addr : mem_addr_q;
      mem_wdata_d = sel_dp ? d_wdata : mem_wdata_q;
      if_gnt_d    = sel_if;
      d_gnt_d     = sel_dp;
      // owner_q: 1 = data port holds the current slot
      owner_d     = mem_en_d ? sel_dp : owner_q;
      state_d     = arb ? (mem_en_d ? GRANT : IDLE)
                  : state_q == GRANT ? (mem_we_q ? IDLE : WAIT)
                  : rd_done ? RESP : WAIT;
      lat_d       = state_q == GRANT ? LW'(RD_LAT - 1) : lat_q - LW'(state_q == WAIT);
      starve_d    = (sel_if || (arb && !if_req)) ? '0
                  : (sel_dp && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) : starve_q;
      // a flush landing on the final WAIT cycle must already suppress the pulse
      kill_d      = state_q == RESP ? 1'b0
                  : kill_q || (if_flush && !owner_q && (state_q == GRANT || state_q == WAIT));
      if_rvalid_d = rd_done && !owner_q && !kill_q && !if_flush;
      d_rvalid_d  = rd_done && owner_q;
      if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
      d_rdata_d   = d_rvalid_d ? mem_rdata : d_rdata_q;
      busy_d      = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         lat_q       <= '0;
         owner_q     <= 1'b0;
         kill_q      <= 1'b0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         lat_q       <= lat_d;
         owner_q     <= owner_d;
         kill_q      <= kill_d;
         if_gnt_q    <= if_gnt_d;
         d_gnt_q     <= d_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end
   assign if_gnt    = if_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_gnt     = d_gnt_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
endmodule
